lynx_keyboard: RTL and testbench
================================

Name: lynx_keyboard

Overview:
- Downstream consumer of the PS/2 byte-receiver/hotkey stage; takes its decoded scancode strobe/byte stream (set 2).
- Tracks make/break state per key in a 10-row x 8-column Lynx keyboard matrix.
- The CPU port decoder reads the matrix one row at a time: row select from address bits A11..A8, active-low column data onto the data bus.
- Handles E0 (extended), F0 (break) and E1 (Pause) prefixes, a prefix timeout, and keyboard self-test/error flush.

Parameters:
- TIMEOUT, 16'd50000, ce ticks a pending prefix may wait for its next byte before it is discarded.
- ROWS, 10, number of implemented matrix rows; row selects >= ROWS read all-released.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable; same enable that drives the PS/2 receiver stage.
- keyStrb  input  1  scancode byte valid; sampled only when ce=1.
- keyCode  input  8  scancode byte, valid with keyStrb.
- row  input  4  matrix row select (CPU A11..A8).
- cols  output  8  selected row, active-low (0 = key down).
- anyKey  output  1  1 when at least one matrix bit is down.
- busy  output  1  1 while a prefix sequence is pending (brk, ext or E1 skip active).

Behaviour:
- Reset (reset=0, async): matrix all released, brk=0, ext=0, skip=0, timer=0. Outputs: cols=8'hFF, anyKey=0, busy=0.
- All state updates occur on posedge clock with ce=1 and keyStrb=1. Bytes arriving with ce=0 are ignored.
- Byte decode, in priority order:
  - skip!=0: skip decrements; the byte is discarded.
  - E1: skip<=7 (discards the remainder of the 8-byte Pause sequence); no matrix change.
  - E0: ext<=1.
  - F0: brk<=1.
  - AA, FC, 00 or FF: flush; matrix all released, brk=0, ext=0.
  - Any other byte: lookup {ext,keyCode} -> {hit,r[3:0],c[2:0]}. If hit, matrix[r][c] <= ~brk (1 = down); otherwise no change. Then brk=0, ext=0.
- Prefix order: F0 after E0 and E0 after F0 are both accepted. The E0 F0 xx and F0 E0 xx forms give the same result.
- Timeout: while brk|ext is set, timer counts ce ticks and clears on each accepted byte.
  - At timer==TIMEOUT-1: brk=0, ext=0, timer=0; matrix unchanged.
  - skip is not subject to the timeout.
- Lookup table: combinational case over 9 bits, per the Lynx keyboard chart. Fixed entries:
  - 12 and 59 (L/R shift) -> r0,c0. Both map to the same bit; the last event wins.
  - 1C (A) -> r2,c6.
  - 29 (space) -> r8,c0.
  - 5A (return) -> r9,c3.
  - 66 (backspace) -> r9,c1.
  - E0 75 (up) -> r6,c2.
  - E0 72 (down) -> r7,c2.
  - 14 (ctrl) -> r1,c3.
  - Unmapped codes and E0 12 (fake shift) -> hit=0.
- Read path: cols = ~matrix[row] combinationally from the matrix register, so it is valid in the same cycle row changes. row>=ROWS gives 8'hFF.
- Update latency: a matrix bit changes on the clock edge that samples the final byte; cols reflects it from the next cycle.
- Typematic repeat makes are idempotent.
- anyKey = OR of all matrix bits, registered one cycle behind the matrix.
- busy = brk | ext | (skip!=0), combinational.
- Reset asserted mid-sequence: abandons the sequence and the matrix; no partial state survives.

Test Plan:
- Reset, then row=0..15 -> cols=FF for all rows, anyKey=0, busy=0.
- Bytes 1C; row=2 -> cols=BF; anyKey=1 one cycle later. Then F0,1C -> cols=FF; busy=1 between F0 and 1C.
- E0,75 -> row6 cols=FB. E0,F0,75 -> FF. Also: 75 with no E0 leaves row6 unchanged (keypad 8, unmapped).
- E1,14,77,E1,F0,14,F0,77 followed by 29 -> ctrl and row1 untouched, row8 cols=FE, busy low after the 8th byte.
- F0, then no byte for TIMEOUT ce ticks, then 5A -> brk expired, row9 cols=F7 (make, not break).
- Hold 12, 1C, 29, then byte AA -> all rows FF, anyKey=0. Separately: async reset pulsed between E0 and 75 -> row6 stays FF after 75.

Source files
------------

// File: rtl/lynx_keyboard_if.sv
// Scancode input, matrix read port and status lines between the
// PS/2 front end / CPU port decoder and the Lynx keyboard matrix.
interface lynx_keyboard_if;
    logic       ce;
    logic       keyStrb;
    logic [7:0] keyCode;
    logic [3:0] row;
    logic [7:0] cols;
    logic       anyKey;
    logic       busy;

    modport master (
        output ce,
        output keyStrb,
        output keyCode,
        output row,
        input  cols,
        input  anyKey,
        input  busy
    );

    modport slave (
        input  ce,
        input  keyStrb,
        input  keyCode,
        input  row,
        output cols,
        output anyKey,
        output busy
    );
endinterface

// File: rtl/lynx_keyboard.sv
// Set-2 scancode stream to Lynx 10x8 key matrix; the CPU reads one
// row at a time as active-low column bits.
module lynx_keyboard #(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter int unsigned ROWS    = 10
) (
    input  logic           clock,
    input  logic           reset,
    lynx_keyboard_if.slave kb
);

    localparam int unsigned COL_W  = 8;
    localparam int unsigned SKIP_W = 3;
    localparam int unsigned TMR_W  = 16;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_F0 = 8'hF0;

    logic [COL_W-1:0]  matrix_q [ROWS];
    logic [COL_W-1:0]  matrix_d [ROWS];
    logic              brk_q, brk_d;
    logic              ext_q, ext_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              any_q;
    logic              any_c;
    logic [COL_W-1:0]  cols_c;

    logic              lut_hit;
    logic [3:0]        lut_row;
    logic [2:0]        lut_col;
    logic [7:0]        lut_c;

    // One table entry: {hit, row, col}
    function automatic logic [7:0] ent(input int unsigned r, input int unsigned c);
        return {1'b1, 4'(r), 3'(c)};
    endfunction

    // Scancode (with extended flag) to matrix position
    always_comb begin
        lut_c = 8'h00;
        case ({ext_q, kb.keyCode})
            9'h012, 9'h059: lut_c = ent(0, 0);   // both shifts share one bit
            9'h016:         lut_c = ent(0, 1);
            9'h076:         lut_c = ent(0, 2);
            9'h015:         lut_c = ent(0, 3);
            9'h026:         lut_c = ent(0, 4);
            9'h024:         lut_c = ent(0, 5);
            9'h01D:         lut_c = ent(0, 6);
            9'h01E:         lut_c = ent(0, 7);
            9'h025:         lut_c = ent(1, 0);
            9'h02D:         lut_c = ent(1, 1);
            9'h02C:         lut_c = ent(1, 2);
            9'h014, 9'h114: lut_c = ent(1, 3);
            9'h023:         lut_c = ent(1, 4);
            9'h01B:         lut_c = ent(1, 5);
            9'h01A:         lut_c = ent(1, 6);
            9'h022:         lut_c = ent(1, 7);
            9'h02E:         lut_c = ent(2, 0);
            9'h036:         lut_c = ent(2, 1);
            9'h035:         lut_c = ent(2, 2);
            9'h02B:         lut_c = ent(2, 3);
            9'h034:         lut_c = ent(2, 4);
            9'h021:         lut_c = ent(2, 5);
            9'h01C:         lut_c = ent(2, 6);
            9'h02A:         lut_c = ent(2, 7);
            9'h03D:         lut_c = ent(3, 0);
            9'h03E:         lut_c = ent(3, 1);
            9'h03C:         lut_c = ent(3, 2);
            9'h043:         lut_c = ent(3, 3);
            9'h033:         lut_c = ent(3, 4);
            9'h03B:         lut_c = ent(3, 5);
            9'h032:         lut_c = ent(3, 6);
            9'h031:         lut_c = ent(3, 7);
            9'h046:         lut_c = ent(4, 0);
            9'h045:         lut_c = ent(4, 1);
            9'h044:         lut_c = ent(4, 2);
            9'h04D:         lut_c = ent(4, 3);
            9'h042:         lut_c = ent(4, 4);
            9'h04B:         lut_c = ent(4, 5);
            9'h03A:         lut_c = ent(4, 6);
            9'h041:         lut_c = ent(4, 7);
            9'h04E:         lut_c = ent(5, 0);
            9'h055:         lut_c = ent(5, 1);
            9'h054:         lut_c = ent(5, 2);
            9'h05B:         lut_c = ent(5, 3);
            9'h04C:         lut_c = ent(5, 4);
            9'h052:         lut_c = ent(5, 5);
            9'h049:         lut_c = ent(5, 6);
            9'h04A:         lut_c = ent(5, 7);
            9'h05D:         lut_c = ent(6, 0);
            9'h00E:         lut_c = ent(6, 1);
            9'h175:         lut_c = ent(6, 2);
            9'h16B:         lut_c = ent(6, 3);
            9'h058:         lut_c = ent(7, 0);
            9'h172:         lut_c = ent(7, 2);
            9'h174:         lut_c = ent(7, 3);
            9'h029:         lut_c = ent(8, 0);
            9'h15A:         lut_c = ent(9, 3);
            9'h066:         lut_c = ent(9, 1);
            9'h05A:         lut_c = ent(9, 3);
            default:        lut_c = 8'h00;
        endcase
    end

    assign lut_hit = lut_c[7];
    assign lut_row = lut_c[6:3];
    assign lut_col = lut_c[2:0];

    // Byte decode and prefix timeout
    always_comb begin
        matrix_d = matrix_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        skip_d   = skip_q;
        timer_d  = timer_q;
        if (kb.ce) begin
            if (kb.keyStrb) begin
                timer_d = '0;
                if (skip_q != '0) begin
                    skip_d = skip_q - SKIP_W'(1);
                end else if (kb.keyCode == CODE_E1) begin
                    skip_d = SKIP_W'(7);
                end else if (kb.keyCode == CODE_E0) begin
                    ext_d = 1'b1;
                end else if (kb.keyCode == CODE_F0) begin
                    brk_d = 1'b1;
                end else if (kb.keyCode == 8'hAA || kb.keyCode == 8'hFC ||
                             kb.keyCode == 8'h00 || kb.keyCode == 8'hFF) begin
                    for (int r = 0; r < int'(ROWS); r++) begin
                        matrix_d[r] = '0;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else begin
                    for (int r = 0; r < int'(ROWS); r++) begin
                        if (lut_hit && lut_row == 4'(r)) begin
                            matrix_d[r][lut_col] = ~brk_q;
                        end
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            end else if (brk_q || ext_q) begin
                if (timer_q == TIMEOUT - TMR_W'(1)) begin
                    brk_d   = 1'b0;
                    ext_d   = 1'b0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end else begin
                timer_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                matrix_q[r] <= '0;
            end
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            skip_q  <= '0;
            timer_q <= '0;
        end else begin
            matrix_q <= matrix_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            skip_q   <= skip_d;
            timer_q  <= timer_d;
        end
    end

    // Any-key summary, one cycle behind the matrix
    always_comb begin
        any_c = 1'b0;
        for (int r = 0; r < int'(ROWS); r++) begin
            any_c = any_c | (|matrix_q[r]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_c;
        end
    end

    // Row read is combinational so the CPU sees it in the same cycle
    always_comb begin
        cols_c = 8'hFF;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (kb.row == 4'(r)) begin
                cols_c = ~matrix_q[r];
            end
        end
    end

    assign kb.cols   = cols_c;
    assign kb.anyKey = any_q;
    assign kb.busy   = brk_q | ext_q | (skip_q != '0);

endmodule

// File: tb/tb_lynx_keyboard.sv
// Directed bench for lynx_keyboard: scancode sequences against
// hand-computed matrix, anyKey and busy values.
module tb_lynx_keyboard;

    localparam logic [15:0] TMO = 16'd100;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    lynx_keyboard_if kb ();

    lynx_keyboard #(.TIMEOUT(TMO), .ROWS(10)) dut (
        .clock (clock),
        .reset (reset),
        .kb    (kb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input int r, input logic [7:0] exp);
        kb.row = 4'(r);
        #1;
        check(tag, kb.cols, exp);
    endtask

    // Present one byte for exactly one posedge, return at the following negedge
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        kb.keyStrb = 1'b1;
        kb.keyCode = b;
        @(negedge clock);
        kb.keyStrb = 1'b0;
        kb.keyCode = 8'h00;
    endtask

    task automatic send_noce(input logic [7:0] b);
        @(negedge clock);
        kb.ce      = 1'b0;
        kb.keyStrb = 1'b1;
        kb.keyCode = b;
        @(negedge clock);
        kb.ce      = 1'b1;
        kb.keyStrb = 1'b0;
        kb.keyCode = 8'h00;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        kb.ce      = 1'b1;
        kb.keyStrb = 1'b0;
        kb.keyCode = 8'h00;
        kb.row     = 4'd0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset state
        for (int r = 0; r < 16; r++) check_row($sformatf("rst_row%0d", r), r, 8'hFF);
        check("rst_any", 8'(kb.anyKey), 8'h00);
        check("rst_busy", 8'(kb.busy), 8'h00);

        // A make/break and anyKey latency
        send(8'h1C);
        check_row("a_make", 2, 8'hBF);
        check("a_any_lag", 8'(kb.anyKey), 8'h00);
        @(negedge clock);
        check("a_any", 8'(kb.anyKey), 8'h01);
        send(8'h1C);
        check_row("a_repeat", 2, 8'hBF);
        send(8'hF0);
        check("f0_busy", 8'(kb.busy), 8'h01);
        check_row("f0_pending", 2, 8'hBF);
        send(8'h1C);
        check_row("a_break", 2, 8'hFF);
        check("a_break_busy", 8'(kb.busy), 8'h00);
        @(negedge clock);
        check("a_any_clr", 8'(kb.anyKey), 8'h00);

        // Extended keys and prefix orders
        send(8'hE0);
        check("e0_busy", 8'(kb.busy), 8'h01);
        send(8'h75);
        check_row("up_make", 6, 8'hFB);
        send(8'h75);
        check_row("kp8_noext", 6, 8'hFB);
        send(8'hF0); send(8'h75);
        check_row("kp8_brk", 6, 8'hFB);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_row("up_brk_e0f0", 6, 8'hFF);
        send(8'hE0); send(8'h75);
        send(8'hF0); send(8'hE0); send(8'h75);
        check_row("up_brk_f0e0", 6, 8'hFF);
        send(8'hE0); send(8'h72);
        check_row("down_make", 7, 8'hFB);
        send(8'hE0); send(8'h12);
        check_row("fake_shift", 0, 8'hFF);
        check_row("row10_held", 10, 8'hFF);
        check_row("row15_held", 15, 8'hFF);
        send(8'hE0); send(8'hF0); send(8'h72);
        check_row("down_brk", 7, 8'hFF);

        // Shifts share a bit, last event wins
        send(8'h12);
        check_row("lshift", 0, 8'hFE);
        send(8'hF0); send(8'h59);
        check_row("rshift_brk", 0, 8'hFF);

        // Pause sequence is swallowed
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        check("pause_busy7", 8'(kb.busy), 8'h01);
        send(8'h77);
        check("pause_busy8", 8'(kb.busy), 8'h00);
        check_row("pause_ctrl", 1, 8'hFF);
        send(8'h29);
        check_row("space_make", 8, 8'hFE);
        check_row("pause_ctrl2", 1, 8'hFF);
        send(8'hF0); send(8'h29);
        check_row("space_brk", 8, 8'hFF);

        // Prefix timeout boundary
        send(8'hF0);
        repeat (int'(TMO) - 1) @(negedge clock);
        check("tmo_before", 8'(kb.busy), 8'h01);
        @(negedge clock);
        check("tmo_after", 8'(kb.busy), 8'h00);
        send(8'h5A);
        check_row("ret_make", 9, 8'hF7);

        // Bytes with ce low are ignored
        send_noce(8'h66);
        check_row("noce_bksp", 9, 8'hF7);
        send(8'h66);
        check_row("bksp_make", 9, 8'hF5);

        // Flush on self-test pass
        send(8'h12); send(8'h1C); send(8'h29);
        check_row("hold_shift", 0, 8'hFE);
        check_row("hold_a", 2, 8'hBF);
        check_row("hold_space", 8, 8'hFE);
        send(8'hF0);
        send(8'hAA);
        check("flush_busy", 8'(kb.busy), 8'h00);
        for (int r = 0; r < 10; r++) check_row($sformatf("flush_row%0d", r), r, 8'hFF);
        @(negedge clock);
        check("flush_any", 8'(kb.anyKey), 8'h00);

        // Reset in the middle of an extended sequence
        send(8'h29);
        send(8'hE0);
        pulse_reset();
        check("mid_rst_busy", 8'(kb.busy), 8'h00);
        check_row("mid_rst_space", 8, 8'hFF);
        send(8'h75);
        check_row("mid_rst_up", 6, 8'hFF);
        check("mid_rst_any", 8'(kb.anyKey), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
